// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display scheduler.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double-dabble correction applied before every shift
    function automatic logic [19:0] bcd_add3(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_display_scheduler_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 never occur and decode to a blank digit.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Binary-to-BCD converter feeding a multiplexed 8-digit display.
// Conversion and scanning run independently; the display register decouples them.
module bcd_display_scheduler
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_DIV - 1);

    state_e      state_q;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [3:0]  cnt_q;
    logic [19:0] disp_q;
    logic [19:0] bcd_adj;

    logic [15:0] refresh_q, refresh_d;
    logic [2:0]  digit_q, digit_d;
    logic [7:0]  an_q;
    logic [6:0]  seg_q, seg_d;

    logic [NUM_DIGITS-1:0][3:0] nibs;
    logic [NUM_DIGITS-1:0]      lit_vec;
    logic [3:0]                 nib;
    logic [6:0]                 dec_seg;
    logic                       above;

    assign bcd_adj = bcd_add3(bcd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q   <= value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[18:0], bin_q[15]};
                    bin_q <= {bin_q[14:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_q  <= bcd_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign dp   = 1'b1;

    always_comb begin
        refresh_d = refresh_q + 16'd1;
        digit_d   = digit_q;
        if (refresh_q == REFRESH_MAX) begin
            refresh_d = '0;
            digit_d   = digit_q + 3'd1;
        end
    end

    // Leading-zero blanking: a digit is lit if it or any higher digit is nonzero
    always_comb begin
        nibs    = '0;
        lit_vec = '0;
        above   = 1'b0;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            nibs[i]    = disp_q[i*4 +: 4];
            above      = above | (disp_q[i*4 +: 4] != 4'd0);
            lit_vec[i] = above | (i == 0);
        end
        nib = nibs[digit_q];
    end

    seg7_decode u_dec (
        .bcd_i (nib),
        .seg_o (dec_seg)
    );

    assign seg_d = lit_vec[digit_q] ? dec_seg : SEG_BLANK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            digit_q   <= '0;
            an_q      <= 8'hFE;
            seg_q     <= SEG_0;
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= ~(8'h01 << digit_q);
            seg_q     <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench: stimulus queues expected BCD results, a monitor
// pops them on done and checks every scanned digit against the model.
module tb_bcd_display_scheduler;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        busy, done, dp;
    logic [7:0]  an;
    logic [6:0]  seg;

    int compared = 0;
    int mismatched = 0;

    logic [19:0] exp_q[$];
    logic [19:0] shown = '0;
    logic [19:0] pend = '0;
    int          pend_dly = 0;
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;

    bcd_display_scheduler #(.REFRESH_DIV(DIV)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [19:0] disp, input int idx);
        int msd = 0;
        for (int i = 0; i < 5; i++)
            if (disp[i*4 +: 4] != 4'd0) msd = i;
        if (idx >= 5 || idx > msd) return 7'h7F;
        return pat(disp[idx*4 +: 4]);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: done pops the scoreboard; new digits appear two cycles later
    always @(negedge clk) begin
        int idx;
        if (pend_dly > 0) begin
            pend_dly--;
            if (pend_dly == 0) shown = pend;
        end
        if (done) begin
            check("done_single", done_prev, 0);
            if (!done_prev) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL done_unexpected: done=1 with no conversion pending");
                end else begin
                    pend = exp_q.pop_front();
                    pend_dly = 2;
                end
            end
        end
        done_prev = done;
        check("dp", dp, 1);
        compared++;
        if ($countones(~an) != 1) begin
            mismatched++;
            $display("FAIL an_onecold: got %0h expected one zero bit", an);
        end else begin
            idx = 0;
            for (int i = 0; i < 8; i++)
                if (!an[i]) idx = i;
            check($sformatf("seg_d%0d_disp%0h", idx, shown), seg,
                  exp_seg(shown, idx));
        end
    end

    task automatic start(input logic [15:0] v, input logic [19:0] bcd,
                         input bit push);
        @(negedge clk);
        load = 1'b1;
        value = v;
        if (push) exp_q.push_back(bcd);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Checks busy/done over cycles k+1..k+18; optional stray load at cycle inj
    task automatic window(input int inj);
        for (int i = 1; i <= 18; i++) begin
            if (i > 1) @(negedge clk);
            check($sformatf("busy_c%0d", i), busy, (i <= 17));
            check($sformatf("done_c%0d", i), done, (i == 17));
            if (inj != 0 && i == inj) begin
                load = 1'b1;
                value = 16'd100;
            end
            if (inj != 0 && i == inj + 1) load = 1'b0;
        end
    endtask

    task automatic conv(input logic [15:0] v, input logic [19:0] bcd);
        start(v, bcd, 1'b1);
        window(0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        logic [7:0] one = 8'h01;
        logic [7:0] ea;

        repeat (3) begin
            @(negedge clk);
            check("rst_an", an, 8'hFE);
            check("rst_seg", seg, 7'h40);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        rst_n = 1'b1;

        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (an == 8'hFD) found = 1;
        end
        check("scan_sync", found, 1);
        for (int d = 1; d <= 8; d++) begin
            ea = ~(one << (d % 8));
            for (int c = 0; c < 4; c++) begin
                if (!(d == 1 && c == 0)) @(negedge clk);
                check($sformatf("scan_d%0d_c%0d", d % 8, c), an, ea);
            end
        end

        conv(16'd1234, 20'h01234);
        conv(16'd65535, 20'h65535);

        start(16'd4321, 20'h04321, 1'b1);
        window(5);
        repeat (40) @(negedge clk);

        conv(16'd0, 20'h00000);

        start(16'd9999, 20'h09999, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        pend_dly = 0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_busy", busy, 0);
            check("midrst_done", done, 0);
            check("midrst_an", an, 8'hFE);
            check("midrst_seg", seg, 7'h40);
        end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        conv(16'd7, 20'h00007);

        @(negedge clk);
        load = 1'b1;
        value = 16'd42;
        repeat (3) exp_q.push_back(20'h00042);
        for (int r = 0; r < 3; r++) begin
            found = 0;
            for (int t = 0; t < 40 && !found; t++) begin
                @(negedge clk);
                if (done) found = 1;
            end
            check($sformatf("b2b_done%0d", r), found, 1);
            @(negedge clk);
            check($sformatf("b2b_gap%0d", r), busy, 0);
            if (r == 2) load = 1'b0;
            @(negedge clk);
            check($sformatf("b2b_restart%0d", r), busy, (r < 2));
        end
        repeat (40) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_display_scheduler.md
BCD_DISPLAY_SCHEDULER -- requirements
Module: bcd_display_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit stays enabled during scanning (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  request to convert and display value; sampled every cycle.
REQ-005 SHALL have port value  input  16  unsigned binary operand; sampled only when a load is accepted.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress; load is ignored while high.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the new result reaches the display register.
REQ-008 SHALL have port an  output  8  active-low digit enables; bit i drives decimal digit i (0 = least significant).
REQ-009 SHALL have port seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 SHALL have port dp  output  1  active-low decimal point; constant 1 (off).

Function
REQ-011 SHALL use a conversion FSM with states IDLE, SHIFT and DONE.
REQ-012 SHALL, in IDLE with load=1, capture value, clear the 20-bit BCD accumulator and shift counter, and go to SHIFT.
REQ-013 SHALL, in each SHIFT cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left one bit (double-dabble), incrementing the shift counter.
REQ-014 SHALL leave SHIFT after exactly 16 shift cycles, go to DONE, and go from DONE to IDLE unconditionally.
REQ-015 SHALL, in DONE, copy the 5 BCD digits into the display register atomically and assert done for that cycle only.
REQ-016 SHALL drive busy = (state != IDLE): for a load accepted at edge k, busy is high for cycles k+1..k+17 and done is high in cycle k+17.
REQ-017 SHALL ignore load while busy=1 (no queueing); a load sampled in the cycle busy falls is accepted.
REQ-018 SHALL keep showing the previous display-register contents until done; the display never shows a partial conversion.
REQ-019 SHALL run a refresh counter 0..REFRESH_DIV-1 independent of the FSM; on wrap, the digit index advances 0..7 and wraps 7->0.
REQ-020 SHALL drive an to all ones except bit [digit index], which is 0.
REQ-021 SHALL blank (seg=7'h7F) digits 5..7 and every leading zero above the most significant nonzero digit; digit 0 is always displayed.
REQ-022 SHALL decode the BCD digits 0..9 to standard seven-segment patterns; a value of 65535 displays as "65535".
REQ-023 SHALL register an and seg, so they change one cycle after the refresh wrap.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, display register=0, refresh counter=0 and digit index=0.
REQ-025 SHALL, while rst_n=0, force an=8'hFE, seg to the pattern for "0" (7'h40) and dp=1.
REQ-026 SHALL, on reset during SHIFT or DONE, abort the conversion with no done pulse; the first load after reset release is accepted normally.

Structure
REQ-027 SHALL define the FSM state enum, the seven-segment pattern constants, NUM_DIGITS=8 and BCD_DIGITS=5 in the shared package bcd_disp_pkg.
REQ-028 SHALL instantiate one sub-module, seg7_decode, a combinational 4-bit BCD to active-low 7-segment decoder.

Verification (bench uses REFRESH_DIV=4)
REQ-029 SHALL check: reset release, no load -> an cycles FE,FD,...,7F with 4 cycles per digit; digit 0 shows 7'h40, all others 7'h7F.
REQ-030 SHALL check: load=1, value=16'd1234 at edge k -> busy high in cycles k+1..k+17, done pulse in cycle k+17; digits 0..3 = 4,3,2,1 and digits 4..7 blank.
REQ-031 SHALL check: value=65535 -> digits 5,3,5,5,6; value=0 -> only digit 0 lit, showing 0.
REQ-032 SHALL check: load=1, value=100 during busy at cycle k+5 -> ignored; result is that of the first load, single done pulse.
REQ-033 SHALL check: rst_n low at cycle k+8 of a conversion of 9999 -> no done pulse; display shows 0; a following load of 7 shows 7.
REQ-034 SHALL check: back-to-back loads (load held high) of 42 -> a new conversion starts in the cycle after each done; the display stays "42" throughout with no glitch.
